// File: rtl/corelet_ctrl_pkg.sv
// Shared definitions for the corelet tile controller: state encoding and mac_array instructions.
package corelet_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WFILL   = 3'd1,
        ST_WLOAD   = 3'd2,
        ST_WSETTLE = 3'd3,
        ST_AFILL   = 3'd4,
        ST_EXEC    = 3'd5,
        ST_DRAIN   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/corelet_ctrl_pump.sv
// sram_to_l0_pump: streams a block of xmem words into L0, one read per cycle,
// writing each word into L0 one cycle after its read (1-cycle SRAM latency).
// A read is withheld while L0 reports full; an already issued read still lands.
module sram_to_l0_pump #(
    parameter int unsigned addr_w = 11,
    parameter int unsigned len_w  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [addr_w-1:0] i_base,
    input  logic [len_w-1:0]  i_count,
    input  logic              i_l0_full,
    output logic              o_xmem_cen,
    output logic [addr_w-1:0] o_xmem_addr,
    output logic              o_l0_wr,
    output logic              o_done
);

    logic              r_active;
    logic [addr_w-1:0] r_addr;
    logic [len_w-1:0]  r_left;
    logic              r_l0_wr;
    logic              w_issue;

    // A read goes out only while words remain and L0 has room.
    assign w_issue     = r_active && (r_left != '0) && !i_l0_full;
    // Finished when every read is out and the final L0 write is happening now.
    assign o_done      = r_active && (r_left == '0) && r_l0_wr;
    assign o_xmem_cen  = !w_issue;
    assign o_xmem_addr = r_addr;
    assign o_l0_wr     = r_l0_wr;

    // Address/remaining counters and the read-to-write delay stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_addr   <= '0;
            r_left   <= '0;
            r_l0_wr  <= 1'b0;
        end else begin
            r_l0_wr <= w_issue;
            if (i_start) begin
                r_active <= 1'b1;
                r_addr   <= i_base;
                r_left   <= i_count;
            end else begin
                if (w_issue) begin
                    r_addr <= r_addr + addr_w'(1);
                    r_left <= r_left - len_w'(1);
                end
                if (o_done) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences one tile -- weight fill, kernel load, settle,
// activation fill, execute, and psum drain from OFIFO into pmem.
module corelet_ctrl
    import corelet_ctrl_pkg::*;
#(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter int unsigned addr_w = 11,
    parameter int unsigned len_w  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [len_w-1:0]  len,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] a_base,
    input  logic [addr_w-1:0] p_base,
    output logic              xmem_cen,
    output logic [addr_w-1:0] xmem_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    input  logic              l0_full,
    output logic [1:0]        inst,
    output logic              ofifo_rd,
    input  logic              ofifo_valid,
    output logic              pmem_cen,
    output logic              pmem_wen,
    output logic [addr_w-1:0] pmem_addr,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [len_w-1:0]  r_len;
    logic [addr_w-1:0] r_a_base;
    logic [addr_w-1:0] r_p_base;
    logic [len_w-1:0]  r_cnt;
    logic [len_w-1:0]  r_pop;

    logic              w_pump_start;
    logic [addr_w-1:0] w_pump_base;
    logic [len_w-1:0]  w_pump_count;
    logic              w_pump_done;
    logic              w_pump_cen;
    logic [addr_w-1:0] w_pump_addr;
    logic              w_pump_wr;
    logic              w_pop;

    sram_to_l0_pump #(
        .addr_w (addr_w),
        .len_w  (len_w)
    ) u_pump (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_pump_start),
        .i_base      (w_pump_base),
        .i_count     (w_pump_count),
        .i_l0_full   (l0_full),
        .o_xmem_cen  (w_pump_cen),
        .o_xmem_addr (w_pump_addr),
        .o_l0_wr     (w_pump_wr),
        .o_done      (w_pump_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pump launch and per-state strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_pump_start = 1'b0;
        w_pump_base  = w_base;
        w_pump_count = len_w'(row);
        l0_rd        = 1'b0;
        inst         = INST_IDLE;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    w_state_nxt  = ST_WFILL;
                    w_pump_start = 1'b1;
                end
            end
            ST_WFILL: begin
                if (w_pump_done) begin
                    w_state_nxt = ST_WLOAD;
                end
            end
            ST_WLOAD: begin
                l0_rd = 1'b1;
                inst  = INST_LOAD;
                if (r_cnt == len_w'(row - 1)) begin
                    w_state_nxt = ST_WSETTLE;
                end
            end
            ST_WSETTLE: begin
                if (r_cnt == len_w'(row + col - 1)) begin
                    w_state_nxt  = ST_AFILL;
                    w_pump_start = 1'b1;
                    w_pump_base  = r_a_base;
                    w_pump_count = r_len;
                end
            end
            ST_AFILL: begin
                if (w_pump_done) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                l0_rd = 1'b1;
                inst  = INST_EXEC;
                w_pop = ofifo_valid && (r_pop != r_len);
                if (r_cnt == (r_len - len_w'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_pop = ofifo_valid && (r_pop != r_len);
                if ((r_pop + len_w'(w_pop)) == r_len) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Tile parameters captured on start, phase cycle counter and pop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len    <= '0;
            r_a_base <= '0;
            r_p_base <= '0;
            r_cnt    <= '0;
            r_pop    <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_WFILL)) begin
                r_len    <= len;
                r_a_base <= a_base;
                r_p_base <= p_base;
                r_pop    <= '0;
            end else if (w_pop) begin
                r_pop <= r_pop + len_w'(1);
            end
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + len_w'(1);
            end
        end
    end

    // OFIFO pops write straight through to pmem in the same cycle.
    assign xmem_cen  = w_pump_cen;
    assign xmem_addr = w_pump_addr;
    assign l0_wr     = w_pump_wr;
    assign ofifo_rd  = w_pop;
    assign pmem_cen  = !w_pop;
    assign pmem_wen  = !w_pop;
    assign pmem_addr = r_p_base + addr_w'(r_pop);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule
